// File: rtl/seg_display_controller.sv
// seg_display_controller: captures a binary value, converts it to four BCD
// digits with an iterative shift-add-3 engine, commits the result atomically
// to a display register and time-multiplexes the four active-low anodes.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Handshake: a value transfers on a rising clk edge where num_valid && num_ready.
// num_ready is high only in IDLE. The source holds num_valid/num stable until
// the transfer edge. num may change freely afterwards.
module seg_display_controller #(
  parameter int NUM_W        = 13,
  parameter int REFRESH_BITS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             num_valid,
  input  logic [NUM_W-1:0] num,
  output logic             num_ready,
  output logic             ovf,
  output logic [3:0]       Anode,
  output logic [6:0]       LED_out,
  output logic [1:0]       dbg_state
);
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, LOAD = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [NUM_W-1:0]        bin_q, bin_d;
  logic [15:0]             bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_lat_q, ovf_lat_d;
  logic [15:0]             disp_q, disp_d;
  logic                    ovf_q, ovf_d;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [3:0]              anode_q, anode_d;
  logic [6:0]              led_q, led_d;
  logic [1:0]              idx, sel;
  logic [3:0]              digit;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic                    blank;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM: capture in IDLE, NUM_W shift steps in CONVERT, commit in LOAD.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_lat_d = ovf_lat_q;
    disp_d    = disp_q;
    ovf_d     = ovf_q;
    num_ready = 1'b0;
    case (state_q)
      IDLE: begin
        num_ready = 1'b1;
        if (num_valid) begin
          bin_d     = num;
          ovf_lat_d = (32'(num) > 32'd9999);
          bcd_d     = '0;
          cnt_d     = CNT_W'(NUM_W);
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = {bcd_adj[14:0], bin_q[NUM_W-1]};
        bin_d = {bin_q[NUM_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = LOAD;
      end
      LOAD: begin
        // Only this state touches the display register, so no partial value shows.
        disp_d  = bcd_q;
        ovf_d   = ovf_lat_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan: top two refresh bits pick the digit; index 0 is the thousands digit.
  always_comb begin
    refresh_d = refresh_q + REFRESH_BITS'(1);
    idx       = refresh_q[REFRESH_BITS-1 -: 2];
    sel       = 2'd3 - idx;
    digit     = disp_q[{sel, 2'b00} +: 4];
    anode_d   = ~(4'b1000 >> idx);
    led_d     = seg_decode(digit);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    blank = 1'b0;
    case (idx)
      2'd0:    blank = (disp_q[15:12] == 4'd0);
      2'd1:    blank = (disp_q[15:8] == 8'd0);
      2'd2:    blank = (disp_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
    if (blank) led_d = 7'b1111111;
`endif
    if (ovf_q) led_d = 7'b1111110;
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_lat_q <= 1'b0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
      refresh_q <= '0;
      anode_q   <= 4'b1111;
      led_q     <= 7'b1111111;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_lat_q <= ovf_lat_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      refresh_q <= refresh_d;
      anode_q   <= anode_d;
      led_q     <= led_d;
    end
  end

  assign ovf       = ovf_q;
  assign Anode     = anode_q;
  assign LED_out   = led_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_display_controller.sv
// Bench for seg_display_controller: a 13-bit instance for the main features and
// a 14-bit instance for overflow. The reference model tracks which decimal value
// is on the display from accept edges and the fixed conversion latency, and
// derives digits with integer divide/modulo.
module tb_seg_display_controller;
  localparam int RB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        num_valid = 1'b0;
  logic [12:0] num = '0;
  logic        num_ready, ovf;
  logic [3:0]  Anode;
  logic [6:0]  LED_out;
  logic [1:0]  dbg_state;

  logic        num_valid_w = 1'b0;
  logic [13:0] num_w = '0;
  logic        num_ready_w, ovf_w;
  logic [3:0]  Anode_w;
  logic [6:0]  LED_w;
  logic [1:0]  dbg_state_w;

  seg_display_controller #(.NUM_W(13), .REFRESH_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .num_valid(num_valid), .num(num),
    .num_ready(num_ready), .ovf(ovf), .Anode(Anode), .LED_out(LED_out),
    .dbg_state(dbg_state)
  );

  seg_display_controller #(.NUM_W(14), .REFRESH_BITS(RB)) dut_w (
    .clk(clk), .rst_n(rst_n), .num_valid(num_valid_w), .num(num_w),
    .num_ready(num_ready_w), .ovf(ovf_w), .Anode(Anode_w), .LED_out(LED_w),
    .dbg_state(dbg_state_w)
  );

  // Clock and reset-relative edge counter.
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  int checks = 0;
  int passes = 0;

  // Scoreboard: values awaiting commit and the edge on which each commits.
  logic [12:0] exp_q[$];
  int          commit_q[$];
  int          shown_val = 0;
  int          btbl[8] = '{0, 9, 10, 99, 100, 999, 1000, 8191};
  int          ovals[4] = '{12000, 42, 10000, 9999};

  function automatic logic [3:0] exp_anode(input int n);
    logic [3:0] one_hot;
    int i;
    if (n == 0) return 4'b1111;
    i = ((n - 1) >> (RB - 2)) % 4;
    one_hot = 4'b1000 >> i;
    return ~one_hot;
  endfunction

  function automatic logic [6:0] exp_led(input int val, input bit ov, input int i);
    int place;
    int d;
    if (ov) return 7'b1111110;
    place = (i == 0) ? 1000 : (i == 1) ? 100 : (i == 2) ? 10 : 1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (i < 3 && val < place) return 7'b1111111;
`endif
    d = (val / place) % 10;
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [6:0] exp_led_at(input int val, input bit ov, input int n);
    if (n == 0) return 7'b1111111;
    return exp_led(val, ov, ((n - 1) >> (RB - 2)) % 4);
  endfunction

  // A committed value is visible on LED_out from the edge after its commit edge.
  task automatic retire();
    while (commit_q.size() > 0 && commit_q[0] <= edge_n - 1) begin
      shown_val = int'(exp_q.pop_front());
      void'(commit_q.pop_front());
    end
  endtask

  // Driver: waits for num_ready, transfers one value, records its commit edge.
  task automatic drive_accept(input logic [12:0] val);
    int k;
    k = 0;
    while (!num_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!num_ready) begin
      $display("FAIL accept_wait: num_ready=%b after %0d cycles, expected 1", num_ready, k);
      return;
    end
    passes++;
    num_valid = 1'b1;
    num = val;
    @(negedge clk);
    num_valid = 1'b0;
    num = 13'($urandom);
    exp_q.push_back(val);
    commit_q.push_back(edge_n + 14);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (Anode !== 4'b1111 || LED_out !== 7'b1111111 || num_ready !== 1'b1 || ovf !== 1'b0)
      $display("FAIL reset_outputs: Anode=%b LED_out=%b ready=%b ovf=%b, expected 1111 1111111 1 0",
               Anode, LED_out, num_ready, ovf);
    else passes++;
    checks++;
    if (Anode_w !== 4'b1111 || LED_w !== 7'b1111111 || num_ready_w !== 1'b1 || ovf_w !== 1'b0)
      $display("FAIL reset_outputs_w: Anode=%b LED_out=%b ready=%b ovf=%b, expected 1111 1111111 1 0",
               Anode_w, LED_w, num_ready_w, ovf_w);
    else passes++;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      retire();
      checks++;
      if (Anode !== exp_anode(edge_n) || LED_out !== exp_led_at(shown_val, 1'b0, edge_n) || num_ready !== 1'b1)
        $display("FAIL idle_scan n=%0d: Anode=%b LED_out=%b ready=%b, expected %b %b 1",
                 edge_n, Anode, LED_out, num_ready, exp_anode(edge_n), exp_led_at(shown_val, 1'b0, edge_n));
      else passes++;
    end
  endtask

  task automatic test_single();
    int lowcnt;
    lowcnt = 0;
    drive_accept(13'd1234);
    for (int k = 0; k < 36; k++) begin
      if (k > 0) @(negedge clk);
      retire();
      if (!num_ready) lowcnt++;
      checks++;
      if (Anode !== exp_anode(edge_n) || LED_out !== exp_led_at(shown_val, 1'b0, edge_n))
        $display("FAIL single_scan n=%0d: Anode=%b LED_out=%b, expected %b %b",
                 edge_n, Anode, LED_out, exp_anode(edge_n), exp_led_at(shown_val, 1'b0, edge_n));
      else passes++;
    end
    checks++;
    if (lowcnt !== 14) $display("FAIL single_busy_cycles: num_ready low %0d cycles, expected 14", lowcnt);
    else passes++;
    checks++;
    if (ovf !== 1'b0) $display("FAIL single_ovf: ovf=%b, expected 0", ovf);
    else passes++;
  endtask

  task automatic test_busy();
    int e0, e1;
    bit got;
    got = 1'b0;
    e1 = -1;
    num_valid = 1'b1;
    num = 13'd8191;
    @(negedge clk);
    num_valid = 1'b0;
    e0 = edge_n;
    exp_q.push_back(13'd8191);
    commit_q.push_back(e0 + 14);
    @(negedge clk);
    num_valid = 1'b1;
    num = 13'd5;
    for (int k = 0; k < 60 && !got; k++) begin
      retire();
      checks++;
      if (Anode !== exp_anode(edge_n) || LED_out !== exp_led_at(shown_val, 1'b0, edge_n))
        $display("FAIL busy_scan n=%0d: Anode=%b LED_out=%b, expected %b %b",
                 edge_n, Anode, LED_out, exp_anode(edge_n), exp_led_at(shown_val, 1'b0, edge_n));
      else passes++;
      if (num_ready) begin
        @(negedge clk);
        num_valid = 1'b0;
        e1 = edge_n;
        exp_q.push_back(13'd5);
        commit_q.push_back(e1 + 14);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (e1 - e0 !== 15) $display("FAIL busy_accept_edge: second accept %0d edges after first, expected 15", e1 - e0);
    else passes++;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      retire();
      checks++;
      if (Anode !== exp_anode(edge_n) || LED_out !== exp_led_at(shown_val, 1'b0, edge_n))
        $display("FAIL busy_scan2 n=%0d: Anode=%b LED_out=%b, expected %b %b",
                 edge_n, Anode, LED_out, exp_anode(edge_n), exp_led_at(shown_val, 1'b0, edge_n));
      else passes++;
    end
    checks++;
    if (shown_val !== 5) $display("FAIL busy_final_value: model shows %0d, expected 5", shown_val);
    else passes++;
  endtask

  task automatic test_blank();
    drive_accept(13'd7);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      retire();
      checks++;
      if (Anode !== exp_anode(edge_n) || LED_out !== exp_led_at(shown_val, 1'b0, edge_n))
        $display("FAIL blank_scan n=%0d: Anode=%b LED_out=%b, expected %b %b",
                 edge_n, Anode, LED_out, exp_anode(edge_n), exp_led_at(shown_val, 1'b0, edge_n));
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] v;
    for (int i = 0; i < 14; i++) begin
      v = (i < 8) ? 13'(btbl[i]) : 13'($urandom_range(0, 8191));
      drive_accept(v);
      for (int k = 0; k < 20 && !num_ready; k++) begin
        retire();
        checks++;
        if (Anode !== exp_anode(edge_n) || LED_out !== exp_led_at(shown_val, 1'b0, edge_n))
          $display("FAIL b2b_scan n=%0d: Anode=%b LED_out=%b, expected %b %b",
                   edge_n, Anode, LED_out, exp_anode(edge_n), exp_led_at(shown_val, 1'b0, edge_n));
        else passes++;
        @(negedge clk);
      end
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      retire();
      checks++;
      if (Anode !== exp_anode(edge_n) || LED_out !== exp_led_at(shown_val, 1'b0, edge_n))
        $display("FAIL b2b_tail n=%0d: Anode=%b LED_out=%b, expected %b %b",
                 edge_n, Anode, LED_out, exp_anode(edge_n), exp_led_at(shown_val, 1'b0, edge_n));
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    drive_accept(13'd4321);
    for (int k = 0; k < 5; k++) begin
      retire();
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (Anode !== 4'b1111 || LED_out !== 7'b1111111 || num_ready !== 1'b1 || ovf !== 1'b0)
      $display("FAIL midreset_outputs: Anode=%b LED_out=%b ready=%b ovf=%b, expected 1111 1111111 1 0",
               Anode, LED_out, num_ready, ovf);
    else passes++;
    exp_q.delete();
    commit_q.delete();
    shown_val = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      retire();
      checks++;
      if (Anode !== exp_anode(edge_n) || LED_out !== exp_led_at(shown_val, 1'b0, edge_n))
        $display("FAIL midreset_scan n=%0d: Anode=%b LED_out=%b, expected %b %b",
                 edge_n, Anode, LED_out, exp_anode(edge_n), exp_led_at(shown_val, 1'b0, edge_n));
      else passes++;
    end
  endtask

  task automatic test_overflow();
    bit prev_ov, exp_ov;
    int k;
    prev_ov = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_ov = (ovals[i] > 9999);
      num_valid_w = 1'b1;
      num_w = 14'(ovals[i]);
      @(negedge clk);
      num_valid_w = 1'b0;
      num_w = 14'($urandom);
      checks++;
      if (ovf_w !== prev_ov) $display("FAIL ovf_hold v=%0d: ovf=%b, expected %b", ovals[i], ovf_w, prev_ov);
      else passes++;
      k = 0;
      while (!num_ready_w && k < 30) begin
        @(negedge clk);
        k++;
      end
      checks++;
      if (k !== 15) $display("FAIL ovf_busy_cycles v=%0d: num_ready low %0d cycles, expected 15", ovals[i], k);
      else passes++;
      checks++;
      if (ovf_w !== exp_ov) $display("FAIL ovf_flag v=%0d: ovf=%b, expected %b", ovals[i], ovf_w, exp_ov);
      else passes++;
      @(negedge clk);
      for (int s = 0; s < 16; s++) begin
        @(negedge clk);
        checks++;
        if (Anode_w !== exp_anode(edge_n) || LED_w !== exp_led_at(ovals[i], exp_ov, edge_n))
          $display("FAIL ovf_scan v=%0d n=%0d: Anode=%b LED_out=%b, expected %b %b", ovals[i], edge_n,
                   Anode_w, LED_w, exp_anode(edge_n), exp_led_at(ovals[i], exp_ov, edge_n));
        else passes++;
      end
      prev_ov = exp_ov;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (state %0d/%0d)", dbg_state, dbg_state_w);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_busy();
    test_blank();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg_display_controller.md
Name: seg_display_controller

Overview:
Sequencing controller for the four-digit seven-segment display on the board.
- Accepts a binary value over a valid/ready handshake.
- Converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine, replacing combinational divide/modulo.
- Commits the result atomically to a display register and time-multiplexes the four anodes.
- Sits between the processor's debug/output selection and the board's Anode/LED_out pins.

Parameters:
NUM_W, 13, width of input value; legal range 4..16.
REFRESH_BITS, 20, refresh counter width; top 2 bits select the digit (each digit active 2^(REFRESH_BITS-2) cycles); minimum 3.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
num_valid  in  1  source presents a value on num
num  in  NUM_W  unsigned binary value to display
num_ready  out  1  controller can accept a value (high only in IDLE)
ovf  out  1  last accepted value > 9999
Anode  out  4  digit enables, active-low; bit 3 = thousands
LED_out  out  7  segments {a,b,c,d,e,f,g}, active-low

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: Anode=4'b1111, LED_out=7'b1111111, num_ready=1, ovf=0.
  - Internals: state=IDLE, refresh counter=0, display register=BCD 0000, conversion shift register cleared.
- FSM states: IDLE, CONVERT, LOAD.
  - IDLE: num_ready=1. On a rising edge with num_valid=1, capture num and set the overflow latch to (num > 9999). Clear the BCD accumulator, load the bit counter with NUM_W, go to CONVERT.
  - CONVERT: each cycle, add 3 to every BCD nibble ≥ 5, then shift left one bit, taking the next num MSB. Decrement the bit counter. On the edge where it reaches 0, go to LOAD. This is exactly NUM_W cycles.
  - LOAD: one cycle. Write the BCD result and the overflow flag to the display register and ovf. Go to IDLE.
- Latency:
  - Accept edge E0 → display register and ovf updated at edge E0+NUM_W+1. This is edge 14 for the default width.
  - num_ready is low from after E0 through the LOAD cycle, and high again in the cycle after the LOAD edge.
- Handshake rules:
  - num_valid while num_ready=0 is ignored; the source holds it until accepted.
  - num may change freely after acceptance.
  - Back-to-back acceptance is legal: one accept every NUM_W+2 cycles maximum.
- Display:
  - Only LOAD updates the display register, so no partial value is ever shown.
  - Old value remains displayed during conversion.
- Overflow:
  - ovf=1 only when NUM_W ≥ 14 and the value exceeds 9999.
  - When ovf=1, every digit shows dash 7'b1111110 regardless of BCD content.
  - ovf clears on the next LOAD of a value ≤ 9999.
- Scan:
  - The free-running refresh counter wraps modulo 2^REFRESH_BITS. Its top 2 bits give the digit index.
  - Index to anode/digit mapping: 00→Anode 0111/thousands, 01→1011/hundreds, 10→1101/tens, 11→1110/units.
  - Anode and LED_out are registered: they reflect the counter and display register one cycle late.
- Decode:
  - 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
  - Any other nibble value shows 0000001.
- Reset mid-operation aborts conversion. No value is committed; the display returns to 0000 on release.
- A scan wrap and a LOAD on the same edge: the new digit is shown from the next registered update; no glitch value is permitted.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits to the left of the most significant nonzero digit output LED_out=7'b1111111; Anode sequencing is unchanged.
  - Value 0 shows only a units "0".
  - Dash display on ovf is unaffected.
- Undefined: all four digits are always displayed, including leading zeros.

Test Plan:
- Bench uses REFRESH_BITS=4.
- Reset and idle: rst_n low then released, no valid → Anode=1111, LED_out=1111111 after reset; first scan shows 0000001 on all four anodes; num_ready=1, ovf=0.
- Single accept: num=1234, valid for 1 cycle → num_ready low 14 cycles; display updates at E0+14; Anode 0111/1011/1101/1110 paired with 1001111/0010010/0000110/1001100.
- Busy handshake: num=8191 accepted, then num=5 held valid from E0+2 → 5 not taken until num_ready=1; 8191 displays (0000000/1001111/0000100/1001111), then 0005 displays 14 cycles after its own accept.
- Reset mid-conversion: accept 4321, drop rst_n at E0+5 for 2 cycles → outputs at reset values immediately; after release, display 0000 and 4321 never appears.
- Leading-zero blanking: num=7 → with macro, thousands/hundreds/tens show 1111111 and units 0001111; without macro, 0000001 ×3 then 0001111.
- Overflow (NUM_W=14): num=12000 → ovf=1, all digits 1111110; then num=42 → ovf=0, display 0042.
